// File: rtl/register_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_arbiter_pkg                                         |
// | Description : Shared register header. Holds the opcode width and opcode   |
// |               encoding that my_register decodes and that every client of  |
// |               the shared register uses to build its commands.             |
// | Contents    : MY_REGISTER_CTRL_WIDTH, OP_* opcode constants, opcode_e.    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package register_arbiter_pkg;

   // Width of the register control input.
   localparam int MY_REGISTER_CTRL_WIDTH = 3;

   // Opcode encoding. Codes 5..7 are unassigned and behave like NOP.
   localparam logic [MY_REGISTER_CTRL_WIDTH-1:0] OP_NOP  = 3'd0;
   localparam logic [MY_REGISTER_CTRL_WIDTH-1:0] OP_CLR  = 3'd1;
   localparam logic [MY_REGISTER_CTRL_WIDTH-1:0] OP_LOAD = 3'd2;
   localparam logic [MY_REGISTER_CTRL_WIDTH-1:0] OP_INCR = 3'd3;
   localparam logic [MY_REGISTER_CTRL_WIDTH-1:0] OP_DECR = 3'd4;

   typedef enum logic [MY_REGISTER_CTRL_WIDTH-1:0] {
      OPC_NOP  = 3'd0,
      OPC_CLR  = 3'd1,
      OPC_LOAD = 3'd2,
      OPC_INCR = 3'd3,
      OPC_DECR = 3'd4
   } opcode_e;

endpackage : register_arbiter_pkg
`default_nettype wire

// File: rtl/register_arbiter_my_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : my_register                                                  |
// | Description : DATA_WIDTH-bit register with CLR / LOAD / INCR / DECR        |
// |               commands. INCR and DECR wrap modulo 2**DATA_WIDTH. NOP and   |
// |               unassigned opcodes leave the contents unchanged.             |
// | Ports       : clk          - clock, rising edge                            |
// |               rst          - synchronous reset, active low                 |
// |               ctrl_i       - opcode, applied on the next rising edge       |
// |               data_i       - load data for LOAD                            |
// |               value_o      - current contents                              |
// |               value_next_o - contents after the pending edge               |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module my_register
   import register_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CTRL_WIDTH = MY_REGISTER_CTRL_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] value_o,
   output logic [DATA_WIDTH-1:0] value_next_o
);

   localparam logic [CTRL_WIDTH-1:0] C_CLR  = CTRL_WIDTH'(OP_CLR);
   localparam logic [CTRL_WIDTH-1:0] C_LOAD = CTRL_WIDTH'(OP_LOAD);
   localparam logic [CTRL_WIDTH-1:0] C_INCR = CTRL_WIDTH'(OP_INCR);
   localparam logic [CTRL_WIDTH-1:0] C_DECR = CTRL_WIDTH'(OP_DECR);
   localparam logic [DATA_WIDTH-1:0] C_ONE  = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] value_q;
   logic [DATA_WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      case (ctrl_i)
         C_CLR:   value_d = '0;
         C_LOAD:  value_d = data_i;
         C_INCR:  value_d = value_q + C_ONE;   // natural wrap all-ones -> 0
         C_DECR:  value_d = value_q - C_ONE;   // natural wrap 0 -> all-ones
         default: value_d = value_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o      = value_q;
   // Exposes the post-operation value so a client can register it in the
   // same edge the register itself updates.
   assign value_next_o = value_d;

endmodule : my_register
`default_nettype wire

// File: rtl/register_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_picker                                                    |
// | Description : Combinational round-robin selector. Returns the first set   |
// |               request bit searching upward from last_i+1, modulo NUM_REQ.  |
// | Ports       : req_i   - request vector                                     |
// |               last_i  - index of the previously granted requester          |
// |               valid_o - at least one request is set                        |
// |               id_o    - selected requester index (0 when none)             |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module rr_picker #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] last_i,
   output logic                valid_o,
   output logic [ID_WIDTH-1:0] id_o
);

   logic [ID_WIDTH-1:0] idx;

   // Walk the offsets from farthest to nearest so the nearest set bit after
   // last_i is the final (winning) assignment; no early exit needed.
   always_comb begin
      valid_o = 1'b0;
      id_o    = '0;
      idx     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_WIDTH'((int'(last_i) + k) % NUM_REQ);
         if (req_i[idx]) begin
            valid_o = 1'b1;
            id_o    = idx;
         end
      end
   end

endmodule : rr_picker
`default_nettype wire

// File: rtl/register_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_arbiter                                             |
// | Description : Round-robin arbiter that shares one my_register instance    |
// |               between NUM_REQ requesters. One transaction every three     |
// |               cycles: IDLE (arbitrate) -> EXEC (grant, drive register) -> |
// |               RESP (done with post-operation value).                      |
// | Ports       : clk     - clock, rising edge                                 |
// |               rst     - synchronous reset, active low                      |
// |               req     - per-requester level request                        |
// |               op      - per-requester opcode, slice i*CTRL_WIDTH           |
// |               wdata   - per-requester load data, slice i*DATA_WIDTH        |
// |               gnt     - one-hot grant pulse (EXEC cycle)                   |
// |               busy    - transaction in progress                            |
// |               done    - completion pulse (RESP cycle)                      |
// |               done_id - completed requester index, valid with done         |
// |               rdata   - register value after the operation, with done      |
// |               value   - live register contents                             |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module register_arbiter
   import register_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CTRL_WIDTH = MY_REGISTER_CTRL_WIDTH,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*CTRL_WIDTH-1:0]  op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           busy,
   output logic                           done,
   output logic [ID_WIDTH-1:0]            done_id,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [DATA_WIDTH-1:0]          value
);

   // State encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [ID_WIDTH-1:0]   C_LAST_RST = ID_WIDTH'(NUM_REQ - 1);
   localparam logic [CTRL_WIDTH-1:0] C_NOP      = CTRL_WIDTH'(OP_NOP);
   localparam logic [NUM_REQ-1:0]    C_GNT_ONE  = NUM_REQ'(1);

   state_e                  state_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ID_WIDTH-1:0]     last_q;
   logic [CTRL_WIDTH-1:0]   op_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic                    done_q;
   logic [ID_WIDTH-1:0]     done_id_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic [CTRL_WIDTH-1:0]   op_arr    [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

   logic                    pick_valid;
   logic [ID_WIDTH-1:0]     pick_id;
   logic [NUM_REQ-1:0]      gnt_d;
   logic [CTRL_WIDTH-1:0]   reg_ctrl;
   logic [DATA_WIDTH-1:0]   reg_next;

   // Unpack the flat per-requester buses into arrays for clean indexing.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i]    = op[i*CTRL_WIDTH +: CTRL_WIDTH];
      assign wdata_arr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_picker (
      .req_i    (req),
      .last_i   (last_q),
      .valid_o  (pick_valid),
      .id_o     (pick_id)
   );

   assign gnt_d = C_GNT_ONE << pick_id;

   // The register only ever sees a real command during EXEC.
   assign reg_ctrl = (state_q == ST_EXEC) ? op_q : C_NOP;

   my_register #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CTRL_WIDTH   (CTRL_WIDTH)
   ) u_reg (
      .clk          (clk),
      .rst          (rst),
      .ctrl_i       (reg_ctrl),
      .data_i       (wdata_q),
      .value_o      (value),
      .value_next_o (reg_next)
   );

   // Control FSM. gnt is set on the IDLE->EXEC edge and done on the
   // EXEC->RESP edge so both are registered one-cycle pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         last_q    <= C_LAST_RST;
         op_q      <= C_NOP;
         wdata_q   <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         rdata_q   <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  id_q    <= pick_id;
                  last_q  <= pick_id;
                  op_q    <= op_arr[pick_id];
                  wdata_q <= wdata_arr[pick_id];
                  gnt_q   <= gnt_d;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Capture the value the register takes on this same edge.
               done_q    <= 1'b1;
               done_id_q <= id_q;
               rdata_q   <= reg_next;
               state_q   <= ST_RESP;
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign rdata   = rdata_q;
   assign busy    = (state_q != ST_IDLE);

endmodule : register_arbiter
`default_nettype wire

// File: doc/register_arbiter.md
# register_arbiter

Shares a single DATA_WIDTH-bit register (one `my_register` instance, internal) between NUM_REQ requesters. Each requester posts one command (NOP/CLR/LOAD/INCR/DECR plus load data) and waits for a grant. The block arbitrates round-robin, drives the register's control/data inputs for exactly one cycle per transaction, and returns the post-operation value tagged with the requester index. It sits between the register-owning datapath and the units that update the shared count.

## Interface
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, register width.
- CTRL_WIDTH, `MY_REGISTER_CTRL_WIDTH`, opcode width.
- ID_WIDTH, $clog2(NUM_REQ), requester index width.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  per-requester request, level.
- op  in  NUM_REQ*CTRL_WIDTH  per-requester opcode, requester i at slice [i*CTRL_WIDTH +: CTRL_WIDTH].
- wdata  in  NUM_REQ*DATA_WIDTH  per-requester load data, same slicing.
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse.
- busy  out  1  transaction in progress (state ≠ IDLE).
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_WIDTH  index of the completed requester; valid with done.
- rdata  out  DATA_WIDTH  register value after the operation; valid with done.
- value  out  DATA_WIDTH  live register contents.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the first set bit searching upward from last+1, modulo NUM_REQ.
  - Latch that requester's id, op and wdata; set last=id; go to EXEC.
- EXEC: gnt[id]=1; drive the register with the latched op and data; go to RESP.
- RESP: done=1, done_id=id, rdata=value (already updated); go to IDLE.
- Opcodes come from the shared register header:
  - CLR → 0.
  - LOAD → wdata.
  - INCR → +1, wrapping all-ones→0.
  - DECR → −1, wrapping 0→all-ones.
  - NOP and any unassigned code → unchanged. This still completes as a read: done is asserted and rdata carries the current value.
- Outside EXEC the register control input is held at NOP.
- Requester rules:
  - Hold req, op and wdata stable until gnt is seen.
  - Drop req by the cycle after gnt, or the same command is re-arbitrated.
  - Dropping req before grant is legal and has no effect.
- Simultaneous requests: round-robin is starvation-free. A continuously asserting requester waits at most NUM_REQ transactions.
- last resets to NUM_REQ−1, so requester 0 wins the first arbitration.
- Reset (rst sampled low), from any state:
  - State returns to IDLE and the latched command is discarded.
  - gnt=0, done=0, done_id=0, rdata=0, busy=0, last=NUM_REQ−1.
  - value=0.
  - No done is ever issued for an aborted transaction.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: EXEC, gnt pulse.
- Cycle 2: RESP, done, rdata = new value; value also shows the new value from cycle 2.
- Cycle 3: IDLE, samples req again.
- Request-to-done latency is 2 cycles; maximum throughput is one transaction per 3 cycles.
- gnt, done, done_id, rdata and busy are registered outputs, with no combinational path from req.
- busy=1 in EXEC and RESP.

## Structure
- Opcode constants and CTRL_WIDTH come from the existing shared register header. No new header is needed.
- State encoding is a localparam inside the block.
- Sub-modules:
  - One `my_register` instance (DATA_WIDTH, CTRL_WIDTH passed through); clk and rst connect directly.
  - One combinational round-robin picker, `rr_picker` (inputs: req and last; outputs: valid and id).

## Test plan
NUM_REQ=4, DATA_WIDTH=8.
- Reset: hold rst=0 for 2 cycles with req=4'b1111 → gnt=0, done=0, busy=0, value=0x00. After release, the first grant goes to requester 0.
- Single LOAD: req[2]=1, op=LOAD, wdata=0xA5 → gnt=4'b0100 at +1, done=1 at +2 with done_id=2 and rdata=0xA5, value=0xA5.
- Fairness: req=4'b1111 all INCR, held permanently, starting from value 0 → grant order 0,1,2,3,0,…, one every 3 cycles; successive rdata 0x01, 0x02, 0x03, 0x04, ….
- Wrap-around: LOAD 0xFF, then INCR → rdata=0x00; then DECR → rdata=0xFF.
- Reset mid-operation: assert rst=0 in the EXEC cycle of a LOAD 0x3C → no done; value=0x00; the next arbitration starts at requester 0.
- NOP, unassigned opcode and CLR: with value=0x5A, a NOP and an unassigned opcode each give done with rdata=0x5A; CLR then gives rdata=0x00.
